nr_refine_seq: RTL



---
 rtl/nr_refine_seq_pkg.sv | 39 +++
 rtl/fp32_mul.sv | 50 +++++
 rtl/fp32_sub_const.sv | 37 +++
 rtl/nr_refine_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/nr_refine_seq_pkg.sv
// Shared definitions for the Newton-Raphson inverse square root refinement engine.
// Contents: FP32 field widths, exponent bias, the 1.5 constant, FSM state encoding,
// and a special-value classifier used by the input check.
package nr_refine_seq_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [FP_W-1:0] FP_THREE_HALVES = 32'h3FC00000;

  typedef enum logic [2:0] {
    IDLE,
    SQ,
    TX,
    SUB,
    UPD,
    DONE
  } state_t;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_neg;
  } fp_class_t;

  // A zero exponent field (true zero or denormal) is classified as zero.
  function automatic fp_class_t fp_classify(input logic [FP_W-1:0] v);
    fp_class_t c;
    c.is_zero = (v[FP_W-2 -: EXP_W] == '0);
    c.is_inf  = (v[FP_W-2 -: EXP_W] == '1) && (v[FRAC_W-1:0] == '0);
    c.is_nan  = (v[FP_W-2 -: EXP_W] == '1) && (v[FRAC_W-1:0] != '0);
    c.is_neg  = v[FP_W-1];
    return c;
  endfunction

endpackage

// File: rtl/fp32_mul.sv
// Purpose: FP32 multiplier, truncating, denormal operands flushed to zero.
// Latency: LAT cycles from operands to product (registered output pipeline).
// Backpressure: none; free-running pipeline, caller holds operands and picks the product.
// Ports: clk, rst (sync active-low), a/b operands, p product.
module fp32_mul
  import nr_refine_seq_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic [23:0] ma, mb;
  logic [47:0] prod;
  logic [9:0]  esum;
  logic [31:0] res;
  logic [31:0] pipe [LAT];

  always_comb begin
    ma   = {1'b1, a[22:0]};
    mb   = {1'b1, b[22:0]};
    prod = {24'b0, ma} * {24'b0, mb};
    // Biased exponent sum plus one when the mantissa product carries into bit 47.
    esum = {2'b0, a[30:23]} + {2'b0, b[30:23]} + {9'b0, prod[47]};
    res  = '0;
    if (a[30:23] != '0 && b[30:23] != '0 && esum > 10'(EXP_BIAS)) begin
      if (esum >= 10'(EXP_BIAS + 255))
        res = {a[31] ^ b[31], 8'hFF, 23'b0};
      else
        res = {a[31] ^ b[31], 8'(esum - 10'(EXP_BIAS)),
               prod[47] ? 23'(prod >> 24) : 23'(prod >> 23)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= res;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[LAT-1];

endmodule

// File: rtl/fp32_sub_const.sv
// Purpose: d = K - p for positive p with exponent in [-8,0], via 30-bit fixed point.
// Latency: combinational.
// Backpressure: none. Ports: p operand, d result (0 on fault), err range fault.
module fp32_sub_const
  import nr_refine_seq_pkg::*;
#(
  parameter logic [31:0] K = FP_THREE_HALVES
) (
  input  logic [31:0] p,
  output logic [31:0] d,
  output logic        err
);

  // Fixed point: bit 29 weighs 2^0, so values below 2.0 fit in 30 bits.
  localparam logic [29:0] KFIX = {1'b1, K[22:0], 6'b0} >> (8'(EXP_BIAS) - K[30:23]);

  logic [7:0]  pe;
  logic        in_range;
  logic [29:0] pf, df;
  logic [4:0]  msb;

  always_comb begin
    pe       = p[30:23];
    in_range = !p[31] && (pe >= 8'(EXP_BIAS - 8)) && (pe <= 8'(EXP_BIAS));
    pf       = {1'b1, p[22:0], 6'b0} >> (8'(EXP_BIAS) - pe);
    df       = KFIX - pf;
    msb      = '0;
    for (int i = 0; i < 30; i++)
      if (df[i]) msb = 5'(i);
    err = !in_range || (pf >= KFIX);
    d   = '0;
    // Renormalise: leading one at bit msb means value 2^(msb-29); fraction truncated.
    if (!err)
      d = {1'b0, 8'(EXP_BIAS - 29) + {3'b0, msb}, 23'((df << (5'd29 - msb)) >> 6)};
  end

endmodule

// File: rtl/nr_refine_seq.sv
// Purpose: Newton-Raphson refinement y <- y*(1.5 - x/2*y^2) on one shared FP32 multiplier.
// Latency: 3*(MUL_LAT+1)+1 cycles per pass; special operands finish right after accept.
// Backpressure: one op in flight; in_ready low from accept until the result is taken.
// Ports: clk, rst (sync active-low), in_valid/in_ready/y0_in/xhalf_in,
//        out_valid/out_ready/y_out/out_err.
module nr_refine_seq
  import nr_refine_seq_pkg::*;
#(
  parameter int          ITERATIONS   = 1,
  parameter int          MUL_LAT      = 1,
  parameter logic [31:0] THREE_HALVES = FP_THREE_HALVES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] y0_in,
  input  logic [31:0] xhalf_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y_out,
  output logic        out_err
);

  localparam logic [7:0] WLAST = 8'(MUL_LAT);

  state_t      state;
  logic [31:0] y_r, xh_r, p_r, d_r;
  logic [7:0]  wcnt;
  logic [1:0]  icnt;
  logic [31:0] mul_a, mul_b, mul_p;
  logic [31:0] sub_d;
  logic        sub_err;
  logic        in_special;

  assign in_special = (|fp_classify(y0_in)) || (|fp_classify(xhalf_in));

  // Operands stay on the multiplier for the whole state so the product is settled
  // by the last cycle, when it is captured.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      SQ:      begin mul_a = y_r; mul_b = y_r;  end
      TX:      begin mul_a = p_r; mul_b = xh_r; end
      UPD:     begin mul_a = y_r; mul_b = d_r;  end
      default: ;
    endcase
  end

  fp32_mul #(.LAT(MUL_LAT)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  fp32_sub_const #(.K(THREE_HALVES)) u_sub (
    .p   (p_r),
    .d   (sub_d),
    .err (sub_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      y_out     <= '0;
      out_err   <= 1'b0;
      icnt      <= '0;
      wcnt      <= '0;
      y_r       <= '0;
      xh_r      <= '0;
      p_r       <= '0;
      d_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            y_r      <= y0_in;
            xh_r     <= xhalf_in;
            icnt     <= '0;
            wcnt     <= '0;
            in_ready <= 1'b0;
            if (in_special) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              y_out     <= y0_in;
            end else begin
              state <= SQ;
            end
          end
        end
        SQ: begin
          if (wcnt == WLAST) begin
            p_r   <= mul_p;
            wcnt  <= '0;
            state <= TX;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        TX: begin
          if (wcnt == WLAST) begin
            p_r   <= mul_p;
            wcnt  <= '0;
            state <= SUB;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        SUB: begin
          d_r <= sub_d;
          if (sub_err) out_err <= 1'b1;
          state <= UPD;
        end
        UPD: begin
          if (wcnt == WLAST) begin
            y_r  <= mul_p;
            wcnt <= '0;
            icnt <= icnt + 2'd1;
            if ((int'(icnt) + 1) < ITERATIONS) begin
              state <= SQ;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              y_out     <= mul_p;
            end
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
